// File: rtl/ndiag_seq_mux_if.sv
// ndiag_seq_mux_if: channel-sequencer bus (controls, packed channels, presented output).
// Optional ch_mask member under NDIAG_SEQ_MASK_EN.
`default_nettype none

interface ndiag_seq_mux_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int IW = $clog2(N);

  logic           start;
  logic           one_shot;
  logic           diag_done;
`ifdef NDIAG_SEQ_MASK_EN
  logic [N-1:0]   ch_mask;
`endif
  logic [N*W-1:0] bu_in;
  logic [W-1:0]   ndiag_out;
  logic           ndiag_valid;
  logic [IW-1:0]  ch_idx;
  logic           seq_done;
  logic           busy;

  modport master (
    output start, one_shot, diag_done,
`ifdef NDIAG_SEQ_MASK_EN
    output ch_mask,
`endif
    output bu_in,
    input  ndiag_out, ndiag_valid, ch_idx, seq_done, busy
  );

  modport slave (
    input  start, one_shot, diag_done,
`ifdef NDIAG_SEQ_MASK_EN
    input  ch_mask,
`endif
    input  bu_in,
    output ndiag_out, ndiag_valid, ch_idx, seq_done, busy
  );
endinterface

`default_nettype wire

// File: rtl/ndiag_seq_mux.sv
// +--------------------------------------------------------------------------+
// | ndiag_seq_mux: round-robin channel sequencer for the non-diagonal stage.  |
// | Optional per-channel enable mask: define NDIAG_SEQ_MASK_EN.               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module ndiag_seq_mux #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  wire             clock,
  input  wire             areset_n,
  ndiag_seq_mux_if.slave  bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_ch_idx;
  logic [W-1:0]  r_ndiag_out;
  logic          r_valid;
  logic          r_seq_done;
  logic          r_one_shot;

  logic          w_any;
  logic [IW-1:0] w_first;
  logic [IW-1:0] w_next;
  logic          w_last;
  logic [W-1:0]  w_first_data;
  logic [W-1:0]  w_next_data;
  logic [W-1:0]  w_cur_data;

`ifdef NDIAG_SEQ_MASK_EN
  assign w_any = |bus.ch_mask;

  // next() only matters when an enabled index above the current one exists,
  // so "lowest enabled index greater than current" covers the circular search.
  always_comb begin
    w_first = '0;
    w_next  = '0;
    w_last  = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.ch_mask[k]) begin
        w_first = IW'(k);
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.ch_mask[k] && (k > int'(r_ch_idx))) begin
        w_next = IW'(k);
        w_last = 1'b0;
      end
    end
  end
`else
  assign w_any   = 1'b1;
  assign w_first = '0;
  assign w_next  = r_ch_idx + 1'b1;
  assign w_last  = (int'(r_ch_idx) == (N - 1));
`endif

  assign w_first_data = bus.bu_in[int'(w_first) * W +: W];
  assign w_next_data  = bus.bu_in[int'(w_next) * W +: W];
  assign w_cur_data   = bus.bu_in[int'(r_ch_idx) * W +: W];

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= S_IDLE;
      r_ch_idx    <= '0;
      r_ndiag_out <= '0;
      r_valid     <= 1'b0;
      r_seq_done  <= 1'b0;
      r_one_shot  <= 1'b0;
    end else begin
      r_seq_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start && w_any) begin
            r_state     <= S_RUN;
            r_ch_idx    <= w_first;
            r_ndiag_out <= w_first_data;
            r_valid     <= 1'b1;
            r_one_shot  <= bus.one_shot;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
`ifdef NDIAG_SEQ_MASK_EN
          if (!w_any) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end else
`endif
          if (bus.start) begin
            r_ch_idx    <= w_first;
            r_ndiag_out <= w_first_data;
            r_one_shot  <= bus.one_shot;
          end else if (bus.diag_done) begin
            if (w_last) begin
              r_seq_done <= 1'b1;
              if (r_one_shot) begin
                r_state <= S_DONE;
                r_valid <= 1'b0;
              end else begin
                r_ch_idx    <= w_first;
                r_ndiag_out <= w_first_data;
              end
            end else begin
              r_ch_idx    <= w_next;
              r_ndiag_out <= w_next_data;
            end
          end else begin
            r_ndiag_out <= w_cur_data;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ndiag_out   = r_ndiag_out;
  assign bus.ndiag_valid = r_valid;
  assign bus.busy        = r_valid;
  assign bus.ch_idx      = r_ch_idx;
  assign bus.seq_done    = r_seq_done;

endmodule

`default_nettype wire

// File: tb/tb_ndiag_seq_mux.sv
// tb_ndiag_seq_mux: directed checks of ndiag_seq_mux against hand-computed values.
`default_nettype none

module tb_ndiag_seq_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic clock;
  logic areset_n;
  int   n_checks;
  int   n_pass;

  ndiag_seq_mux_if #(.N(N), .W(W)) bus ();

  ndiag_seq_mux #(.N(N), .W(W)) dut (
    .clock    (clock),
    .areset_n (areset_n),
    .bus      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] exp_seq [6];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_seq  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11, 32'h22};

    areset_n      = 1'b0;
    bus.start     = 1'b0;
    bus.one_shot  = 1'b0;
    bus.diag_done = 1'b0;
`ifdef NDIAG_SEQ_MASK_EN
    bus.ch_mask   = 4'b1111;
`endif
    bus.bu_in     = {32'h44, 32'h33, 32'h22, 32'h11};

    #12;
    check("rst_out",   bus.ndiag_out, 32'h0);
    check("rst_valid", 32'(bus.ndiag_valid), 32'h0);
    check("rst_idx",   32'(bus.ch_idx), 32'h0);
    check("rst_done",  32'(bus.seq_done), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    areset_n = 1'b1;
    tick();

    // continuous pass with one wrap
    bus.start = 1'b1; bus.one_shot = 1'b0;
    tick();
    bus.start = 1'b0;
    check("cont_start_out", bus.ndiag_out, 32'h11);
    check("cont_start_idx", 32'(bus.ch_idx), 32'h0);
    check("cont_start_vld", 32'(bus.ndiag_valid), 32'h1);
    for (int p = 1; p <= 5; p++) begin
      bus.diag_done = 1'b1;
      tick();
      bus.diag_done = 1'b0;
      check($sformatf("cont_out%0d", p), bus.ndiag_out, exp_seq[p]);
      check($sformatf("cont_sdone%0d", p), 32'(bus.seq_done), (p == 4) ? 32'h1 : 32'h0);
      check($sformatf("cont_vld%0d", p), 32'(bus.ndiag_valid), 32'h1);
    end

    // live tracking on channel 1
    bus.bu_in[1*W +: W] = 32'hDEADBEEF;
    tick();
    check("live_out", bus.ndiag_out, 32'hDEADBEEF);
    check("live_idx", 32'(bus.ch_idx), 32'h1);
    bus.bu_in[1*W +: W] = 32'h22;
    tick();

    // start beats diag_done at ch_idx 2
    bus.diag_done = 1'b1;
    tick();
    check("pre_sim_idx", 32'(bus.ch_idx), 32'h2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.diag_done = 1'b0;
    check("sim_idx",   32'(bus.ch_idx), 32'h0);
    check("sim_out",   bus.ndiag_out, 32'h11);
    check("sim_sdone", 32'(bus.seq_done), 32'h0);

    // one-shot pass
    bus.start = 1'b1; bus.one_shot = 1'b1;
    tick();
    bus.start = 1'b0; bus.one_shot = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      bus.diag_done = 1'b1;
      tick();
      bus.diag_done = 1'b0;
      check($sformatf("os_idx%0d", p), 32'(bus.ch_idx), 32'(p));
    end
    bus.diag_done = 1'b1;
    tick();
    bus.diag_done = 1'b0;
    check("os_sdone", 32'(bus.seq_done), 32'h1);
    check("os_vld",   32'(bus.ndiag_valid), 32'h0);
    check("os_busy",  32'(bus.busy), 32'h0);
    check("os_out",   bus.ndiag_out, 32'h44);
    tick();
    check("os_sdone_clr", 32'(bus.seq_done), 32'h0);
    bus.diag_done = 1'b1;
    tick();
    bus.diag_done = 1'b0;
    check("os_ign_out",   bus.ndiag_out, 32'h44);
    check("os_ign_idx",   32'(bus.ch_idx), 32'h3);
    check("os_ign_vld",   32'(bus.ndiag_valid), 32'h0);
    check("os_ign_sdone", 32'(bus.seq_done), 32'h0);

    // asynchronous reset at ch_idx 2
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.diag_done = 1'b1;
    tick();
    tick();
    bus.diag_done = 1'b0;
    check("pre_rst_idx", 32'(bus.ch_idx), 32'h2);
    #2 areset_n = 1'b0;
    #1;
    check("arst_out", bus.ndiag_out, 32'h0);
    check("arst_idx", 32'(bus.ch_idx), 32'h0);
    check("arst_vld", 32'(bus.ndiag_valid), 32'h0);
    #1 areset_n = 1'b1;
    tick();
    check("arst_idle_vld", 32'(bus.ndiag_valid), 32'h0);

`ifdef NDIAG_SEQ_MASK_EN
    bus.ch_mask = 4'b1010;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("mask_first", 32'(bus.ch_idx), 32'h1);
    for (int p = 1; p <= 3; p++) begin
      bus.diag_done = 1'b1;
      tick();
      bus.diag_done = 1'b0;
      check($sformatf("mask_idx%0d", p), 32'(bus.ch_idx), (p == 2) ? 32'h1 : 32'h3);
      check($sformatf("mask_sdone%0d", p), 32'(bus.seq_done), (p == 2) ? 32'h1 : 32'h0);
    end
    bus.ch_mask = 4'b0000;
    tick();
    check("abort_vld",   32'(bus.ndiag_valid), 32'h0);
    check("abort_idx",   32'(bus.ch_idx), 32'h3);
    check("abort_sdone", 32'(bus.seq_done), 32'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("nomask_start_vld", 32'(bus.ndiag_valid), 32'h0);
    bus.ch_mask = 4'b1111;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ndiag_seq_mux.md
# ndiag_seq_mux

Parametrised round-robin sequencer that presents one of N W-bit block-update channels at a time to the non-diagonal datapath. It advances to the next channel each time the diagonal stage reports `diag_done`. It adds three things: a registered output with a valid flag, continuous or one-shot sequencing, and an optional per-channel enable mask. It sits between the block-update producers and the non-diagonal processing unit of the UKF covariance pipeline.

## Interface
- `N`, 4: channel count, ≥2.
- `W`, 32: channel data width.
- `IW`, `$clog2(N)`: index width; derived, not overridden.

- `clock` in 1: single clock, rising edge.
- `areset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins or restarts a sequence.
- `one_shot` in 1: mode select; sampled only when `start` is accepted. 1 = single pass, 0 = wrap forever.
- `diag_done` in 1: advance request; meaningful only in RUN.
- `ch_mask` in N: channel enables, bit k = channel k. Present only with `NDIAG_SEQ_MASK_EN`.
- `bu_in` in N*W: packed channels; channel k at `[k*W +: W]`.
- `ndiag_out` out W: registered data of the current channel.
- `ndiag_valid` out 1: high while in RUN.
- `ch_idx` out IW: current channel index.
- `seq_done` out 1: one-cycle pulse after the last channel of a pass is consumed.
- `busy` out 1: high while in RUN; identical to `ndiag_valid`.

## Operation
- **Reset values:** state IDLE, `ch_idx`=0, `ndiag_out`=0, `ndiag_valid`=0, `seq_done`=0, `busy`=0, latched mode=continuous.
- **FSM states:** IDLE, RUN, DONE.
- **first** = lowest enabled channel index.
- **next(i)** = the next enabled index after i, searching circularly.
- **Last channel:** i is the last channel when no enabled index is greater than i.
- **IDLE/DONE, `start`=1, at least one channel enabled:**
  - go to RUN; `ch_idx`←first; `ndiag_out`←`bu_in[first]`; latch `one_shot`.
- **IDLE/DONE, `start`=1, no channel enabled:** `start` is ignored.
- **DONE:** lasts exactly one cycle, then goes to IDLE unless `start` is accepted.
- **RUN, `start`=1:** restart at first. `start` has priority over `diag_done`, which is dropped that cycle. `seq_done` is not pulsed.
- **RUN, `diag_done`=1, not last channel:** `ch_idx`←next(ch_idx); `ndiag_out`←`bu_in[next]`.
- **RUN, `diag_done`=1, last channel:**
  - `seq_done`←1 for one cycle.
  - Continuous mode: `ch_idx`←first and stay in RUN.
  - One-shot mode: go to DONE; `ndiag_valid`←0; `ch_idx` and `ndiag_out` hold.
- **RUN, no event:** `ndiag_out`←`bu_in[ch_idx]` every cycle, so live input changes propagate with one-cycle latency.
- **RUN, mask becomes all-zero:** abort to IDLE at the next edge. `ndiag_valid`←0, `seq_done` stays 0, `ch_idx` holds.
- **RUN, current channel masked off:** the current channel keeps being presented until `diag_done`. It then advances via next(); when the current channel is masked, the last-channel test uses the same rule.
- **Outside RUN:** `diag_done` is ignored.
- **Reset asserted mid-sequence:** all outputs return to reset values immediately (asynchronous).

## Timing
- `start` sampled at edge k → at edge k: RUN, `ndiag_valid`=1, `ch_idx`=first, `ndiag_out`=`bu_in[first]` as sampled at k.
- `diag_done` sampled at edge k → `ch_idx` and `ndiag_out` updated at edge k. Latency is 1 cycle from the request to the new data.
- `seq_done` is registered: high for exactly the cycle following the consuming edge.
- Back-to-back `diag_done` on consecutive cycles advances one channel per cycle. A full N-channel pass takes N cycles at minimum.
- All inputs are synchronous to `clock`; the block has no internal synchronisers.

## Configuration
- `NDIAG_SEQ_MASK_EN` defined: the `ch_mask` port exists, and skip and abort behave as above.
- `NDIAG_SEQ_MASK_EN` undefined:
  - `ch_mask` port is absent; all N channels are always enabled, first=0, next(i)=(i+1) mod N.
  - The mask-abort path and the all-zero mask check are not synthesised.

## Test plan
- **Reset then continuous run (N=4, W=32):** `bu_in` = {0x44,0x33,0x22,0x11}; pulse `start` with `one_shot`=0; 5 `diag_done` pulses → `ndiag_out` sequence 0x11,0x22,0x33,0x44,0x11,0x22; `seq_done` high once, the cycle after the 4th pulse; `ndiag_valid` stays 1.
- **One-shot:** `start` with `one_shot`=1; 4 `diag_done` pulses → `seq_done`=1 and `ndiag_valid`=0 together; DONE for 1 cycle, then IDLE; `ndiag_out` holds 0x44; a 5th `diag_done` has no effect.
- **Simultaneous `start` and `diag_done` at `ch_idx`=2:** → `ch_idx`=0, `ndiag_out`=0x11, `seq_done`=0.
- **Mask (macro on):** `ch_mask`=4'b1010; `start`, then 3 `diag_done` → `ch_idx` 1,3,1,3; `seq_done` pulses after the 2nd pulse. Driving `ch_mask`=0 mid-RUN → IDLE next edge, `ndiag_valid`=0. `start` with `ch_mask`=0 → stays IDLE.
- **Live data tracking:** in RUN at `ch_idx`=1, change channel 1 to 0xDEADBEEF with no `diag_done` → `ndiag_out`=0xDEADBEEF one cycle later.
- **Reset mid-operation:** drop `areset_n` at `ch_idx`=2 between clock edges → all outputs go to 0 and state to IDLE before the next edge.
